// File: rtl/sh2_load_wb_ctrl.sv
// ---------------------------------------------------------------------------
// sh2_load_wb_ctrl
//
// Load-return writeback controller for the SH2 register file late write port.
// Each issued load queues its destination and format. The big-endian bus
// data that comes back is lane-selected, extended and parked in a HOLD
// register that drives WB_ADDR/WB_D/WBE. Decode reads that hit a pending
// destination raise a load-use interlock.
//
// Optional feature: define SH2_LDWB_FWD_EN to forward HOLD/LAT data to the
// decode read ports instead of stalling. When it is undefined, FWD_* are
// tied to 0 and every match stalls.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   CE                   pipeline advance; the regfile latches WB port when 1
//   LD_ISSUE/LD_DST/LD_SIZE/LD_SIGNED/LD_ALO  load issue (qualified by CE)
//   LD_FULL              queue full
//   OVF_ERR              sticky: issue dropped while full, or ack when empty
//   BUS_ACK/BUS_DI       returning load data, in issue order
//   BUS_RDY              controller can take BUS_ACK this cycle
//   RDA_*/RDB_*          decode read addresses and use flags
//   HAZ_STALL            load-use interlock (combinational)
//   FWD_A_*/FWD_B_*      forwarded data per read port
//   WB_ADDR/WB_D/WBE     regfile late write port
// ---------------------------------------------------------------------------
module sh2_load_wb_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        LD_ISSUE,
  input  logic [4:0]  LD_DST,
  input  logic [1:0]  LD_SIZE,
  input  logic        LD_SIGNED,
  input  logic [1:0]  LD_ALO,
  output logic        LD_FULL,
  output logic        OVF_ERR,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_DI,
  output logic        BUS_RDY,
  input  logic [4:0]  RDA_ADDR,
  input  logic        RDA_USE,
  input  logic [4:0]  RDB_ADDR,
  input  logic        RDB_USE,
  output logic        HAZ_STALL,
  output logic        FWD_A_V,
  output logic [31:0] FWD_A_D,
  output logic        FWD_B_V,
  output logic [31:0] FWD_B_D,
  output logic [4:0]  WB_ADDR,
  output logic [31:0] WB_D,
  output logic        WBE
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Lane select and extension of raw big-endian bus data.
  function automatic logic [31:0] fmt_load(input logic [31:0] di,
                                           input logic [1:0]  size,
                                           input logic        sgn,
                                           input logic [1:0]  alo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (alo)
      2'd0:    b = di[31:24];
      2'd1:    b = di[23:16];
      2'd2:    b = di[15:8];
      default: b = di[7:0];
    endcase
    h = alo[1] ? di[15:0] : di[31:16];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = di;
    endcase
    return res;
  endfunction

  // Queue storage; a per-entry valid bit makes full/empty and the hazard
  // scan independent of pointer arithmetic.
  logic [DEPTH-1:0] r_q_v;
  logic [4:0]       r_q_dst  [DEPTH];
  logic [1:0]       r_q_size [DEPTH];
  logic             r_q_sgn  [DEPTH];
  logic [1:0]       r_q_alo  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_ovf;

  logic             r_hold_v;
  logic [4:0]       r_hold_dst;
  logic [31:0]      r_hold_data;
  logic             r_lat_v;
  logic [4:0]       r_lat_dst;
`ifdef SH2_LDWB_FWD_EN
  logic [31:0]      r_lat_data;
`endif

  logic w_full;
  logic w_empty;
  logic w_bus_rdy;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_ack_empty;

  assign w_full      = &r_q_v;
  assign w_empty     = ~|r_q_v;
  assign w_bus_rdy   = ~r_hold_v | CE;
  assign w_pop       = BUS_ACK & w_bus_rdy & ~w_empty;
  assign w_ack_empty = BUS_ACK & w_bus_rdy & w_empty;
  // A full queue still accepts an issue when the head leaves this cycle.
  assign w_push      = CE & LD_ISSUE & (~w_full | w_pop);
  assign w_drop      = CE & LD_ISSUE & w_full & ~w_pop;

  // Queue entries and pointers. When full and popping, push targets the
  // slot being vacated, so the push assignment must come last.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q_v    <= {DEPTH{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_q_dst[i]  <= 5'd0;
        r_q_size[i] <= 2'd0;
        r_q_sgn[i]  <= 1'b0;
        r_q_alo[i]  <= 2'd0;
      end
    end else begin
      if (w_pop) begin
        r_q_v[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_ONE;
      end
      if (w_push) begin
        r_q_v[r_wr_ptr]    <= 1'b1;
        r_q_dst[r_wr_ptr]  <= LD_DST;
        r_q_size[r_wr_ptr] <= LD_SIZE;
        r_q_sgn[r_wr_ptr]  <= LD_SIGNED;
        r_q_alo[r_wr_ptr]  <= LD_ALO;
        r_wr_ptr           <= r_wr_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_drop | w_ack_empty;
    end
  end

  // HOLD: loaded on pop, otherwise cleared once the regfile has latched it
  // on a CE cycle. A pop during a drain simply overwrites it (no bubble).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold_v    <= 1'b0;
      r_hold_dst  <= 5'd0;
      r_hold_data <= 32'd0;
    end else if (w_pop) begin
      r_hold_v    <= 1'b1;
      r_hold_dst  <= r_q_dst[r_rd_ptr];
      r_hold_data <= fmt_load(BUS_DI, r_q_size[r_rd_ptr], r_q_sgn[r_rd_ptr],
                              r_q_alo[r_rd_ptr]);
    end else if (CE) begin
      r_hold_v    <= 1'b0;
    end
  end

  // LAT: remembers the entry drained on the last CE cycle, covering the
  // cycle between regfile latch and the RAM write actually landing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lat_v    <= 1'b0;
      r_lat_dst  <= 5'd0;
`ifdef SH2_LDWB_FWD_EN
      r_lat_data <= 32'd0;
`endif
    end else if (CE) begin
      r_lat_v    <= r_hold_v;
      r_lat_dst  <= r_hold_dst;
`ifdef SH2_LDWB_FWD_EN
      r_lat_data <= r_hold_data;
`endif
    end
  end

  // Per-port match against queue, HOLD and LAT.
  logic w_qm_a, w_qm_b;
  logic w_hm_a, w_hm_b;
  logic w_lm_a, w_lm_b;

  // Scan every valid queue entry for a destination match.
  always_comb begin
    w_qm_a = 1'b0;
    w_qm_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_qm_a = w_qm_a | (r_q_v[i] & (r_q_dst[i] == RDA_ADDR));
      w_qm_b = w_qm_b | (r_q_v[i] & (r_q_dst[i] == RDB_ADDR));
    end
  end

  assign w_hm_a = r_hold_v & (r_hold_dst == RDA_ADDR);
  assign w_hm_b = r_hold_v & (r_hold_dst == RDB_ADDR);
  assign w_lm_a = r_lat_v & (r_lat_dst == RDA_ADDR);
  assign w_lm_b = r_lat_v & (r_lat_dst == RDB_ADDR);

`ifdef SH2_LDWB_FWD_EN
  logic w_fwd_a_v, w_fwd_b_v;
  // Queue matches have no data yet and must stall; HOLD is newer than LAT
  // so it wins when both match.
  assign w_fwd_a_v = RDA_USE & ~w_qm_a & (w_hm_a | w_lm_a);
  assign w_fwd_b_v = RDB_USE & ~w_qm_b & (w_hm_b | w_lm_b);
  assign HAZ_STALL = (RDA_USE & w_qm_a) | (RDB_USE & w_qm_b);
  assign FWD_A_V   = w_fwd_a_v;
  assign FWD_B_V   = w_fwd_b_v;
  assign FWD_A_D   = ~w_fwd_a_v ? 32'd0 : (w_hm_a ? r_hold_data : r_lat_data);
  assign FWD_B_D   = ~w_fwd_b_v ? 32'd0 : (w_hm_b ? r_hold_data : r_lat_data);
`else
  assign HAZ_STALL = (RDA_USE & (w_qm_a | w_hm_a | w_lm_a)) |
                     (RDB_USE & (w_qm_b | w_hm_b | w_lm_b));
  assign FWD_A_V   = 1'b0;
  assign FWD_B_V   = 1'b0;
  assign FWD_A_D   = 32'd0;
  assign FWD_B_D   = 32'd0;
`endif

  assign LD_FULL = w_full;
  assign OVF_ERR = r_ovf;
  assign BUS_RDY = w_bus_rdy;
  assign WBE     = r_hold_v;
  assign WB_ADDR = r_hold_dst;
  assign WB_D    = r_hold_data;

endmodule

// File: tb/tb_sh2_load_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sh2_load_wb_ctrl
//
// Directed bench for sh2_load_wb_ctrl. Issued loads are remembered in a
// local issue queue; each accepted ack turns its head into an expected
// writeback {dst, data} pushed onto a scoreboard. A negedge monitor pops and
// compares whenever the regfile would latch the WB port (CE & WBE).
// ---------------------------------------------------------------------------
module tb_sh2_load_wb_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, CE, LD_ISSUE, LD_SIGNED, BUS_ACK;
  logic [4:0]  LD_DST, RDA_ADDR, RDB_ADDR, WB_ADDR;
  logic [1:0]  LD_SIZE, LD_ALO;
  logic [31:0] BUS_DI, FWD_A_D, FWD_B_D, WB_D;
  logic        RDA_USE, RDB_USE;
  logic        LD_FULL, OVF_ERR, BUS_RDY, HAZ_STALL, FWD_A_V, FWD_B_V, WBE;

  always #5 CLK = ~CLK;

  sh2_load_wb_ctrl #(.DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .LD_ISSUE(LD_ISSUE), .LD_DST(LD_DST), .LD_SIZE(LD_SIZE),
    .LD_SIGNED(LD_SIGNED), .LD_ALO(LD_ALO),
    .LD_FULL(LD_FULL), .OVF_ERR(OVF_ERR),
    .BUS_ACK(BUS_ACK), .BUS_DI(BUS_DI), .BUS_RDY(BUS_RDY),
    .RDA_ADDR(RDA_ADDR), .RDA_USE(RDA_USE),
    .RDB_ADDR(RDB_ADDR), .RDB_USE(RDB_USE),
    .HAZ_STALL(HAZ_STALL),
    .FWD_A_V(FWD_A_V), .FWD_A_D(FWD_A_D),
    .FWD_B_V(FWD_B_V), .FWD_B_D(FWD_B_D),
    .WB_ADDR(WB_ADDR), .WB_D(WB_D), .WBE(WBE)
  );

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] alo;
  } ld_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_t;

  ld_t iq[$];
  wb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Reference formatter: shift the addressed lane down, then extend.
  function automatic logic [31:0] m_fmt(input logic [31:0] di, input logic [1:0] size,
                                        input logic sgn, input logic [1:0] alo);
    logic [31:0] sh;
    int          k;
    case (size)
      2'b00: begin
        k  = 3 - int'(alo);
        sh = di >> (8 * k);
        return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      end
      2'b01: begin
        sh = alo[1] ? di : (di >> 16);
        return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      end
      default: return di;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a CE cycle with WBE=1 is one regfile write.
  always @(negedge CLK) begin
    wb_t e;
    if (RST_N && CE && WBE) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL sb_underflow: observed write addr %0d data 0x%08h expected none",
               WB_ADDR, WB_D);
      end else begin
        e = sb.pop_front();
        chk("sb_wb_addr", 32'(WB_ADDR), 32'(e.dst));
        chk("sb_wb_data", WB_D, e.data);
      end
    end
  end

  // One clock with an optional accepted issue and/or accepted ack.
  task automatic step(input logic iss, input logic [4:0] dst, input logic [1:0] size,
                      input logic sgn, input logic [1:0] alo,
                      input logic ack, input logic [31:0] di);
    ld_t l;
    wb_t w;
    LD_ISSUE = iss; LD_DST = dst; LD_SIZE = size; LD_SIGNED = sgn; LD_ALO = alo;
    BUS_ACK = ack; BUS_DI = di;
    if (ack && iq.size() > 0) begin
      l = iq.pop_front();
      w.dst  = l.dst;
      w.data = m_fmt(di, l.size, l.sgn, l.alo);
      sb.push_back(w);
    end
    if (iss) begin
      l.dst = dst; l.size = size; l.sgn = sgn; l.alo = alo;
      iq.push_back(l);
    end
    @(posedge CLK); #1;
    LD_ISSUE = 1'b0;
    BUS_ACK  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; CE = 1'b1; LD_ISSUE = 1'b0; LD_DST = 5'd0; LD_SIZE = 2'd0;
    LD_SIGNED = 1'b0; LD_ALO = 2'd0; BUS_ACK = 1'b0; BUS_DI = 32'd0;
    RDA_ADDR = 5'd0; RDA_USE = 1'b0; RDB_ADDR = 5'd0; RDB_USE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wbe", 32'(WBE), 32'd0);
    chk("rst_wb_addr", 32'(WB_ADDR), 32'd0);
    chk("rst_wb_d", WB_D, 32'd0);
    chk("rst_full", 32'(LD_FULL), 32'd0);
    chk("rst_ovf", 32'(OVF_ERR), 32'd0);
    chk("rst_bus_rdy", 32'(BUS_RDY), 32'd1);
    chk("rst_haz", 32'(HAZ_STALL), 32'd0);
    chk("rst_fwd_a_v", 32'(FWD_A_V), 32'd0);
    RST_N = 1'b1;
    idle();

    // 1: long load, one-cycle ack-to-WB latency
    step(1'b1, 5'd3, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    RDA_ADDR = 5'd3; RDA_USE = 1'b1; #1;
    chk("t1_haz_queue", 32'(HAZ_STALL), 32'd1);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h89ABCDEF);
    chk("t1_wbe", 32'(WBE), 32'd1);
    chk("t1_wb_addr", 32'(WB_ADDR), 32'd3);
    chk("t1_wb_d", WB_D, 32'h89ABCDEF);
    idle();
    chk("t1_wbe_drained", 32'(WBE), 32'd0);
    idle();
    chk("t1_haz_clear", 32'(HAZ_STALL), 32'd0);
    RDA_USE = 1'b0;

    // 2: lane select and extension, back-to-back acks
    step(1'b1, 5'd1, 2'b00, 1'b1, 2'd2, 1'b0, 32'd0);
    step(1'b1, 5'd2, 2'b00, 1'b0, 2'd2, 1'b0, 32'd0);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0011F233);
    chk("t2_byte_s", WB_D, 32'hFFFFFFF2);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0011F233);
    chk("t2_byte_u", WB_D, 32'h000000F2);
    chk("t2_no_bubble", 32'(WBE), 32'd1);
    step(1'b1, 5'd9, 2'b01, 1'b1, 2'd2, 1'b0, 32'd0);
    step(1'b1, 5'd16, 2'b01, 1'b0, 2'd1, 1'b1, 32'h12348001);
    chk("t2_word_s", WB_D, 32'hFFFF8001);
    step(1'b1, 5'd12, 2'b00, 1'b1, 2'd3, 1'b1, 32'hBEEF1234);
    chk("t2_word_alo1", WB_D, 32'h0000BEEF);
    chk("t2_pr_addr", 32'(WB_ADDR), 32'd16);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hFFFFFF7F);
    chk("t2_byte_alo3", WB_D, 32'h0000007F);
    idle(); idle();

    // 3: overflow with DEPTH=2
    step(1'b1, 5'd1, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    step(1'b1, 5'd2, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    chk("t3_full", 32'(LD_FULL), 32'd1);
    chk("t3_ovf_pre", 32'(OVF_ERR), 32'd0);
    LD_ISSUE = 1'b1; LD_DST = 5'd4;   // dropped: no issue-queue entry
    @(posedge CLK); #1;
    LD_ISSUE = 1'b0;
    chk("t3_ovf_set", 32'(OVF_ERR), 32'd1);
    step(1'b1, 5'd6, 2'b10, 1'b0, 2'd0, 1'b1, 32'h11111111);
    chk("t3_full_swap", 32'(LD_FULL), 32'd1);
    chk("t3_ovf_kept", 32'(OVF_ERR), 32'd1);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h22222222);
    chk("t3_not_full", 32'(LD_FULL), 32'd0);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h66666666);
    chk("t3_last_dst", 32'(WB_ADDR), 32'd6);
    idle(); idle();

    // 4: load-use interlock through queue, HOLD and LAT
    RDA_ADDR = 5'd5; RDA_USE = 1'b1; RDB_ADDR = 5'd5;
    step(1'b1, 5'd5, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    chk("t4_haz_queue", 32'(HAZ_STALL), 32'd1);
    RDA_USE = 1'b0; #1;
    chk("t4_no_use", 32'(HAZ_STALL), 32'd0);
    RDA_USE = 1'b1;
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D);
`ifdef SH2_LDWB_FWD_EN
    chk("t4_haz_hold", 32'(HAZ_STALL), 32'd0);
    chk("t4_fwd_a_v", 32'(FWD_A_V), 32'd1);
    chk("t4_fwd_a_d", FWD_A_D, 32'hCAFEF00D);
`else
    chk("t4_haz_hold", 32'(HAZ_STALL), 32'd1);
    chk("t4_fwd_a_v", 32'(FWD_A_V), 32'd0);
`endif
    RDA_USE = 1'b0; RDB_USE = 1'b1;
    idle();
`ifdef SH2_LDWB_FWD_EN
    chk("t4_haz_lat", 32'(HAZ_STALL), 32'd0);
    chk("t4_fwd_b_d", FWD_B_D, 32'hCAFEF00D);
`else
    chk("t4_haz_lat", 32'(HAZ_STALL), 32'd1);
    chk("t4_fwd_b_v", 32'(FWD_B_V), 32'd0);
`endif
    idle();
    chk("t4_haz_clear", 32'(HAZ_STALL), 32'd0);
    RDB_USE = 1'b0;

    // 5: CE low blocks drain and second ack; CE high drains and reloads
    step(1'b1, 5'd7, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    step(1'b1, 5'd8, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    CE = 1'b0;
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h77777777);
    chk("t5_hold_wbe", 32'(WBE), 32'd1);
    chk("t5_rdy_low", 32'(BUS_RDY), 32'd0);
    BUS_ACK = 1'b1; BUS_DI = 32'h88888888;   // offered, must not be taken
    @(posedge CLK); #1;
    chk("t5_hold_kept", WB_D, 32'h77777777);
    chk("t5_rdy_still_low", 32'(BUS_RDY), 32'd0);
    CE = 1'b1; #1;
    chk("t5_rdy_ce", 32'(BUS_RDY), 32'd1);
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h88888888);
    chk("t5_reload_addr", 32'(WB_ADDR), 32'd8);
    chk("t5_reload_wbe", 32'(WBE), 32'd1);
    idle(); idle();

    // 6: reset mid-operation discards everything
    step(1'b1, 5'd10, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    step(1'b1, 5'd11, 2'b10, 1'b0, 2'd0, 1'b0, 32'd0);
    step(1'b1, 5'd12, 2'b10, 1'b0, 2'd0, 1'b1, 32'hAAAA0000);
    chk("t6_full_pre", 32'(LD_FULL), 32'd1);
    RDA_ADDR = 5'd11; RDA_USE = 1'b1;
    RST_N = 1'b0; #1;
    chk("t6_rst_wbe", 32'(WBE), 32'd0);
    chk("t6_rst_full", 32'(LD_FULL), 32'd0);
    chk("t6_rst_haz", 32'(HAZ_STALL), 32'd0);
    chk("t6_rst_ovf", 32'(OVF_ERR), 32'd0);
    iq.delete();
    sb.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1; RDA_USE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_no_wb", 32'(WBE), 32'd0);
    end
    step(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h12345678);   // ack on empty queue
    chk("t6_empty_ack_ovf", 32'(OVF_ERR), 32'd1);
    chk("t6_empty_ack_wbe", 32'(WBE), 32'd0);
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
